// File: rtl/ravan_cipher_core.sv
// ravan_cipher_core: iterative tweakable block cipher engine (encrypt/decrypt).
//
// One xor/invert/add step per clock, one key slice per step, ROUNDS full passes over the
// SLICES = KEY_W/DATA_W key slices. Decrypt walks the slices in reverse and inverts each step.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous reset, active-low
//   in_valid  block offered            in_ready   engine idle, can accept
//   mode      0 = encrypt, 1 = decrypt (sampled at accept)
//   data_in   input block              tweak      tweak word (sampled at accept)
//   key       KEY_W key, slice k = key[k*DATA_W +: DATA_W] (sampled at accept)
//   out_valid result available         out_ready  downstream accepts result
//   data_out  result block             busy       engine in RUN or DONE
//
// Optional build macro RAVAN_ZEROIZE_EN: clears latched key/tweak/work on the output
// handshake, and forces data_out to 0 whenever out_valid is low.
module ravan_cipher_core #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned KEY_W  = 512,
    parameter int unsigned ROUNDS = 21
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mode,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] tweak,
    input  logic [KEY_W-1:0]  key,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              busy
);
    localparam int unsigned SLICES = KEY_W / DATA_W;
    localparam int unsigned SW     = $clog2(SLICES);
    localparam int unsigned RW     = $clog2(ROUNDS + 1);
    localparam logic [SW-1:0] SLICE_LAST = SW'(SLICES - 1);
    localparam logic [RW-1:0] ROUND_LAST = RW'(ROUNDS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] work_q, work_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic [DATA_W-1:0] tweak_q, tweak_d;
    logic              mode_q, mode_d;
    logic [SW-1:0]     slice_q, slice_d;
    logic [RW-1:0]     round_q, round_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              ovalid_q, ovalid_d;

    logic [DATA_W-1:0] k_slice;
    logic [DATA_W-1:0] step_enc;
    logic [DATA_W-1:0] step_dec;
    logic [DATA_W-1:0] step;
    logic              last_slice;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            work_q   <= '0;
            key_q    <= '0;
            tweak_q  <= '0;
            mode_q   <= 1'b0;
            slice_q  <= '0;
            round_q  <= '0;
            dout_q   <= '0;
            ovalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            key_q    <= key_d;
            tweak_q  <= tweak_d;
            mode_q   <= mode_d;
            slice_q  <= slice_d;
            round_q  <= round_d;
            dout_q   <= dout_d;
            ovalid_q <= ovalid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        key_d    = key_q;
        tweak_d  = tweak_q;
        mode_d   = mode_q;
        slice_d  = slice_q;
        round_d  = round_q;
        dout_d   = dout_q;
        ovalid_d = ovalid_q;

        k_slice  = key_q[slice_q*DATA_W +: DATA_W];
        step_enc = (~(work_q ^ k_slice)) + tweak_q;
        // Exact inverse of the encrypt step: subtract tweak, invert, remove key.
        step_dec = (~(work_q - tweak_q)) ^ k_slice;
        step     = mode_q ? step_dec : step_enc;
        last_slice = mode_q ? (slice_q == '0) : (slice_q == SLICE_LAST);

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    work_d  = data_in;
                    key_d   = key;
                    tweak_d = tweak;
                    mode_d  = mode;
                    slice_d = mode ? SLICE_LAST : '0;
                    round_d = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                work_d = step;
                if (mode_q) begin
                    slice_d = last_slice ? SLICE_LAST : slice_q - 1'b1;
                end else begin
                    slice_d = last_slice ? '0 : slice_q + 1'b1;
                end
                if (last_slice) begin
                    round_d = round_q + 1'b1;
                    if (round_q == ROUND_LAST) begin
                        dout_d   = step;
                        ovalid_d = 1'b1;
                        state_d  = StDone;
                    end
                end
            end
            StDone: begin
                if (out_ready) begin
                    ovalid_d = 1'b0;
                    state_d  = StIdle;
`ifdef RAVAN_ZEROIZE_EN
                    key_d    = '0;
                    tweak_d  = '0;
                    work_d   = '0;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_valid = ovalid_q;
`ifdef RAVAN_ZEROIZE_EN
    assign data_out  = ovalid_q ? dout_q : '0;
`else
    assign data_out  = dout_q;
`endif

endmodule

// File: tb/tb_ravan_cipher_core.sv
module tb_ravan_cipher_core;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Small configuration: DATA_W=8, KEY_W=16, ROUNDS=1
    logic        s_in_valid, s_in_ready, s_mode, s_out_valid, s_out_ready, s_busy;
    logic [7:0]  s_data_in, s_tweak, s_data_out;
    logic [15:0] s_key;

    // Default configuration
    logic         b_in_valid, b_in_ready, b_mode, b_out_valid, b_out_ready, b_busy;
    logic [63:0]  b_data_in, b_tweak, b_data_out;
    logic [511:0] b_key;

    ravan_cipher_core #(.DATA_W(8), .KEY_W(16), .ROUNDS(1)) u_small (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .mode(s_mode),
        .data_in(s_data_in), .tweak(s_tweak), .key(s_key), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .data_out(s_data_out), .busy(s_busy)
    );

    ravan_cipher_core u_big (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .mode(b_mode),
        .data_in(b_data_in), .tweak(b_tweak), .key(b_key), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .data_out(b_data_out), .busy(b_busy)
    );

    function automatic logic [63:0] model_enc(input logic [63:0] x, input logic [511:0] k,
                                              input logic [63:0] t);
        logic [63:0] w;
        w = x;
        for (int r = 0; r < 21; r++)
            for (int s = 0; s < 8; s++)
                w = (~(w ^ k[s*64 +: 64])) + t;
        return w;
    endfunction

    task automatic small_txn(input logic m, input logic [7:0] d, input logic [15:0] k,
                             input logic [7:0] t, output logic [7:0] res, output int lat);
        @(negedge clk);
        s_mode = m; s_data_in = d; s_key = k; s_tweak = t; s_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_in_valid = 1'b0; s_key = ~k; s_tweak = ~t; s_mode = ~m;
        lat = 0;
        while (!s_out_valid && lat < 50) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        res = s_data_out;
        s_out_ready = 1'b1;
        @(negedge clk);
        s_out_ready = 1'b0;
    endtask

    task automatic big_txn(input logic m, input logic [63:0] d, input logic [511:0] k,
                           input logic [63:0] t, output logic [63:0] res, output int lat);
        @(negedge clk);
        b_mode = m; b_data_in = d; b_key = k; b_tweak = t; b_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        // Scrambled inputs during RUN must have no effect.
        b_in_valid = 1'b0; b_key = ~k; b_tweak = ~t; b_mode = ~m; b_data_in = ~d;
        lat = 0;
        while (!b_out_valid && lat < 400) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        res = b_data_out;
        b_out_ready = 1'b1;
        @(negedge clk);
        b_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        s_in_valid = 0; s_mode = 0; s_data_in = '0; s_tweak = '0; s_key = '0; s_out_ready = 0;
        b_in_valid = 0; b_mode = 0; b_data_in = '0; b_tweak = '0; b_key = '0; b_out_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({s_in_ready, s_out_valid, s_busy, s_data_out} !== {3'b100, 8'h00}) begin
            errors++;
            $display("FAIL reset_small: got rdy=%b ov=%b busy=%b dout=%h, need 1 0 0 00",
                     s_in_ready, s_out_valid, s_busy, s_data_out);
        end
        checks++;
        if ({b_in_ready, b_out_valid, b_busy, b_data_out} !== {3'b100, 64'h0}) begin
            errors++;
            $display("FAIL reset_big: got rdy=%b ov=%b busy=%b dout=%h, need 1 0 0 0",
                     b_in_ready, b_out_valid, b_busy, b_data_out);
        end
        rst = 1'b1;
        // out_ready while nothing is pending must do nothing
        s_out_ready = 1'b1;
        @(negedge clk);
        s_out_ready = 1'b0;
        checks++;
        if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_out_ready: got ov=%b rdy=%b, need 0 1", s_out_valid, s_in_ready);
        end
    endtask

    task automatic test_small_vectors();
        logic [7:0] vin [4]  = '{8'h00, 8'hFF, 8'h5A, 8'h5D};
        logic       vm  [4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0] vexp [4] = '{8'hFF, 8'h00, 8'h5D, 8'h5A};
        logic [7:0] res;
        int lat;
        for (int i = 0; i < 4; i++) begin
            small_txn(vm[i], vin[i], 16'h0201, 8'h03, res, lat);
            checks++;
            if (lat != 2) begin
                errors++;
                $display("FAIL small_latency[%0d]: got %0d, need 2", i, lat);
            end
            checks++;
            if (res !== vexp[i]) begin
                errors++;
                $display("FAIL small_data[%0d]: got %h, need %h", i, res, vexp[i]);
            end
        end
    endtask

    task automatic test_roundtrip();
        logic [511:0] k;
        logic [63:0]  t, x, ct, pt, exp_ct;
        int lat;
        for (int v = 0; v < 200; v++) begin
            for (int j = 0; j < 16; j++) k[j*32 +: 32] = $urandom;
            t = {$urandom, $urandom};
            x = {$urandom, $urandom};
            exp_ct = model_enc(x, k, t);
            big_txn(1'b0, x, k, t, ct, lat);
            checks++;
            if (lat != 168) begin
                errors++;
                $display("FAIL enc_latency[%0d]: got %0d, need 168", v, lat);
            end
            checks++;
            if (ct !== exp_ct) begin
                errors++;
                $display("FAIL enc_data[%0d]: got %h, need %h", v, ct, exp_ct);
            end
            big_txn(1'b1, ct, k, t, pt, lat);
            checks++;
            if (lat != 168) begin
                errors++;
                $display("FAIL dec_latency[%0d]: got %0d, need 168", v, lat);
            end
            checks++;
            if (pt !== x) begin
                errors++;
                $display("FAIL dec_roundtrip[%0d]: got %h, need %h", v, pt, x);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [511:0] k;
        logic [63:0]  t, x1, x2, r1, exp1, exp2, exp_idle;
        int lat;
        for (int j = 0; j < 16; j++) k[j*32 +: 32] = 32'h1111_1111 * (j + 1);
        t = 64'h0123_4567_89AB_CDEF;
        x1 = 64'hDEAD_BEEF_0000_0001;
        x2 = 64'h0BAD_F00D_1234_5678;
        exp1 = model_enc(x1, k, t);
        exp2 = model_enc(x2, k, t);
        @(negedge clk);
        b_mode = 0; b_data_in = x1; b_key = k; b_tweak = t; b_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_in_valid = 1'b0;
        lat = 0;
        while (!b_out_valid && lat < 400) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        r1 = b_data_out;
        checks++;
        if (r1 !== exp1) begin
            errors++;
            $display("FAIL bp_first: got %h, need %h", r1, exp1);
        end
        // Offer a new block while the result is stalled.
        b_data_in = x2; b_in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if ({b_out_valid, b_in_ready, b_busy} !== 3'b101 || b_data_out !== exp1) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got ov=%b rdy=%b busy=%b dout=%h, need 1 0 1 %h",
                         c, b_out_valid, b_in_ready, b_busy, b_data_out, exp1);
            end
        end
        b_out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        b_out_ready = 1'b0;
`ifdef RAVAN_ZEROIZE_EN
        exp_idle = 64'h0;
`else
        exp_idle = exp1;
`endif
        checks++;
        if ({b_out_valid, b_in_ready, b_busy} !== 3'b010 || b_data_out !== exp_idle) begin
            errors++;
            $display("FAIL bp_release: got ov=%b rdy=%b busy=%b dout=%h, need 0 1 0 %h",
                     b_out_valid, b_in_ready, b_busy, b_data_out, exp_idle);
        end
        @(posedge clk); @(negedge clk);
        b_in_valid = 1'b0;
        checks++;
        if (b_busy !== 1'b1 || b_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_accept: got busy=%b rdy=%b, need 1 0", b_busy, b_in_ready);
        end
        lat = 0;
        while (!b_out_valid && lat < 400) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        checks++;
        if (lat != 168 || b_data_out !== exp2) begin
            errors++;
            $display("FAIL bp_second: got lat=%0d dout=%h, need 168 %h", lat, b_data_out, exp2);
        end
        b_out_ready = 1'b1;
        @(negedge clk);
        b_out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int seen;
        @(negedge clk);
        b_mode = 0; b_data_in = 64'hCAFE; b_key = {8{64'h5555_AAAA_0F0F_F0F0}};
        b_tweak = 64'h77; b_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_in_valid = 1'b0;
        repeat (49) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        checks++;
        if ({b_out_valid, b_in_ready, b_busy} !== 3'b010 || b_data_out !== 64'h0) begin
            errors++;
            $display("FAIL mid_reset: got ov=%b rdy=%b busy=%b dout=%h, need 0 1 0 0",
                     b_out_valid, b_in_ready, b_busy, b_data_out);
        end
        seen = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); @(negedge clk);
            if (b_out_valid || b_busy) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL aborted_block: got %0d active cycles, need 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_small_vectors();
        test_backpressure();
        test_reset_mid_run();
        test_roundtrip();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ravan_cipher_core.md
Name: ravan_cipher_core

Overview:
- Parametrised, handshaked successor to the RAVAN 64-bit decryption engine; encrypts or decrypts one block per transaction under a wide key.
- Key is sliced into SLICES = KEY_W/DATA_W subkeys. Each round applies all subkeys, one per clock, through an invertible xor/invert/add step keyed by a tweak word.
- Iterative: one step per cycle, ROUNDS*SLICES cycles per block.
- Sits between the RAVAN key/data staging logic and the output buffer; valid/ready on both sides.

Parameters:
- DATA_W, 64, block and tweak width in bits.
- KEY_W, 512, key width; must be an integer multiple of DATA_W, with SLICES = KEY_W/DATA_W >= 2.
- ROUNDS, 21, number of full rounds; must be >= 1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low (0 = reset).
- in_valid  in  1  input block offered.
- in_ready  out  1  engine can accept a block.
- mode  in  1  0 = encrypt, 1 = decrypt; sampled at accept.
- data_in  in  DATA_W  plaintext (enc) or ciphertext (dec).
- tweak  in  DATA_W  tweak word T; sampled at accept.
- key  in  KEY_W  key; slice k = key[k*DATA_W +: DATA_W]; sampled at accept.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts result.
- data_out  out  DATA_W  result block.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (rst=0 at a clock edge): state=IDLE; in_ready=1; out_valid=0; busy=0; data_out=0; all internal registers (work, key, tweak, mode, counters) are 0. Reset mid-RUN or mid-DONE aborts the block, and no output is produced.
- FSM IDLE -> RUN -> DONE -> IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready: latch data_in into work, and latch key, tweak, mode. Set slice_cnt = 0 (enc) or SLICES-1 (dec), round_cnt=0, then go to RUN.
- RUN: in_ready=0. One step per edge with K = key slice slice_cnt, arithmetic mod 2^DATA_W.
  - Encrypt step: work = (~(work ^ K)) + T. slice_cnt increments, wrapping SLICES-1 -> 0 and incrementing round_cnt.
  - Decrypt step: work = (~(work - T)) ^ K. slice_cnt decrements, wrapping 0 -> SLICES-1 and incrementing round_cnt.
  - On the step with round_cnt==ROUNDS-1 and the last slice of the round, load data_out with the step result, set out_valid=1, and go to DONE.
- Latency: out_valid rises exactly ROUNDS*SLICES edges after the accepting edge (default 168).
- DONE: out_valid=1 and data_out held stable until out_ready=1. On that edge out_valid=0 and the state returns to IDLE.
- in_ready stays 0 in DONE, so a new block is not accepted on the same edge as output handoff. Minimum block period is ROUNDS*SLICES+2 cycles.
- Inputs are ignored outside IDLE; changes to key/tweak/mode during RUN have no effect.
- out_ready asserted while out_valid=0 has no effect.
- Decrypt(Encrypt(x)) == x for identical key, tweak, ROUNDS.
- busy = (state != IDLE).

Optional Feature:
- Macro RAVAN_ZEROIZE_EN.
- Defined:
  - On the output handshake edge, the latched key, tweak, and work registers clear to 0.
  - data_out reads 0 whenever out_valid=0.
- Undefined:
  - Latched registers retain their last values.
  - data_out holds the last result until the next completion or reset.

Test Plan:
- Small config DATA_W=8, KEY_W=16, ROUNDS=1, key=16'h0201, tweak=8'h03, encrypt data_in=8'h00 -> out_valid exactly 2 edges after accept, data_out=8'hFF.
- Same config, decrypt data_in=8'hFF -> data_out=8'h00 after 2 edges.
- Defaults, random key/tweak/block, encrypt then decrypt result -> recovered block equals original; out_valid at edge +168 each time; 200 random vectors.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> data_out stable, in_ready=0, a new in_valid is ignored; out_ready=1 -> IDLE next edge, then the block is accepted.
- Reset mid-RUN (rst=0 at step 50 for 1 cycle) -> next edge out_valid=0, in_ready=1, busy=0, data_out=0; the aborted block never appears.
- With RAVAN_ZEROIZE_EN, after handshake -> data_out=0 while idle. Without it -> data_out keeps the last result.
